// File: rtl/mux_arb_2to1_4bit_if.sv
// Handshake bundle for mux_arb_2to1_4bit: two requester channels and one output channel.
// The slave modport is the arbiter's view; the master modport is the producers' and consumer's view.
interface mux_arb_2to1_4bit_if #(
    parameter int WIDTH = 4
);
    logic             in0_valid;
    logic [WIDTH-1:0] in0_data;
    logic             in0_ready;
    logic             in1_valid;
    logic [WIDTH-1:0] in1_data;
    logic             in1_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_ready;

    modport slave (
        input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
        output in0_ready, in1_ready, out_valid, out_data, out_src
    );

    modport master (
        output in0_valid, in0_data, in1_valid, in1_data, out_ready,
        input  in0_ready, in1_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/mux_arb_2to1_4bit.sv
// 2-requester arbiter with a single-entry registered output buffer on the shared select path.
// MUX_ARB_ROUND_ROBIN_EN selects round-robin priority; when undefined, in0 has fixed priority.
//
// state    | meaning
// ST_EMPTY | output buffer holds no word (out_valid=0)
// ST_FULL  | output buffer holds a word waiting for out_ready
module mux_arb_2to1_4bit #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux_arb_2to1_4bit_if.slave   bus
);
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    logic             r_src;

    logic w_can_accept;
    logic w_grant0;
    logic w_grant1;
    logic w_pref1;

`ifdef MUX_ARB_ROUND_ROBIN_EN
    logic r_pref1;

    // Pointer moves only on a real grant; it then favours the other requester.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pref1 <= 1'b0;
        end else if (w_grant0) begin
            r_pref1 <= 1'b1;
        end else if (w_grant1) begin
            r_pref1 <= 1'b0;
        end
    end

    assign w_pref1 = r_pref1;
`else
    assign w_pref1 = 1'b0;
`endif

    // rst_n is folded in so no requester sees ready while reset is held.
    assign w_can_accept = rst_n & ((r_state == ST_EMPTY) | bus.out_ready);
    assign w_grant0     = w_can_accept & bus.in0_valid & (~bus.in1_valid | ~w_pref1);
    assign w_grant1     = w_can_accept & bus.in1_valid & (~bus.in0_valid |  w_pref1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_data  <= '0;
            r_src   <= 1'b0;
        end else if (w_grant0) begin
            r_state <= ST_FULL;
            r_data  <= bus.in0_data;
            r_src   <= 1'b0;
        end else if (w_grant1) begin
            r_state <= ST_FULL;
            r_data  <= bus.in1_data;
            r_src   <= 1'b1;
        end else if (bus.out_ready) begin
            r_state <= ST_EMPTY;
        end
    end

    assign bus.in0_ready = w_grant0;
    assign bus.in1_ready = w_grant1;
    assign bus.out_valid = (r_state == ST_FULL);
    assign bus.out_data  = r_data;
    assign bus.out_src   = r_src;
endmodule

// File: tb/tb_mux_arb_2to1_4bit.sv
// Scoreboard bench for mux_arb_2to1_4bit: stimulus pushes expected {src,data} per grant,
// a negedge monitor pops and compares on every output handshake.
module tb_mux_arb_2to1_4bit;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    logic [4:0] exp_q[$];

    mux_arb_2to1_4bit_if #(.WIDTH(4)) bus ();

    mux_arb_2to1_4bit #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: a word is consumed at the next posedge when out_valid & out_ready.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_unexpected: got src=%0d data=%h, required no word", bus.out_src, bus.out_data);
            end else begin
                logic [4:0] e;
                e = exp_q.pop_front();
                if ({bus.out_src, bus.out_data} !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard_word: got src=%0d data=%h, required src=%0d data=%h",
                             bus.out_src, bus.out_data, e[4], e[3:0]);
                end
            end
        end
    end

    task automatic check_out(input string name, input logic v, input logic [3:0] d, input logic s);
        n_tests++;
        if (bus.out_valid !== v || bus.out_data !== d || bus.out_src !== s) begin
            n_fail++;
            $display("FAIL %s: got valid=%b data=%h src=%b, required valid=%b data=%h src=%b",
                     name, bus.out_valid, bus.out_data, bus.out_src, v, d, s);
        end
    endtask

    // Apply one cycle of inputs, check readies at negedge, queue expected grants.
    task automatic step(input string name, input logic rn,
                        input logic v0, input logic [3:0] d0,
                        input logic v1, input logic [3:0] d1,
                        input logic ordy, input logic er0, input logic er1);
        rst_n         = rn;
        bus.in0_valid = v0;
        bus.in0_data  = d0;
        bus.in1_valid = v1;
        bus.in1_data  = d1;
        bus.out_ready = ordy;
        @(negedge clk);
        n_tests++;
        if (bus.in0_ready !== er0 || bus.in1_ready !== er1) begin
            n_fail++;
            $display("FAIL %s_ready: got r0=%b r1=%b, required r0=%b r1=%b",
                     name, bus.in0_ready, bus.in1_ready, er0, er1);
        end
        if (!rn) exp_q.delete();
        if (er0) exp_q.push_back({1'b0, d0});
        if (er1) exp_q.push_back({1'b1, d1});
        @(posedge clk);
        #1;
    endtask

    logic       rr;
    logic [3:0] rel_d;
    logic       rel_s;

    initial begin
        n_tests = 0;
        n_fail  = 0;
`ifdef MUX_ARB_ROUND_ROBIN_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        rel_s = rr;
        rel_d = rr ? 4'hC : 4'h3;

        rst_n = 1'b0;
        bus.in0_valid = 1'b1; bus.in0_data = 4'h3;
        bus.in1_valid = 1'b1; bus.in1_data = 4'hC;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset held with both requesters valid
        for (int i = 0; i < 3; i++) begin
            check_out("reset_out", 1'b0, 4'h0, 1'b0);
            step("reset", 1'b0, 1'b1, 4'h3, 1'b1, 4'hC, 1'b1, 1'b0, 1'b0);
        end

        // Single source on in1
        check_out("pre_single", 1'b0, 4'h0, 1'b0);
        step("single", 1'b1, 1'b0, 4'h0, 1'b1, 4'hA, 1'b1, 1'b0, 1'b1);
        check_out("single_out", 1'b1, 4'hA, 1'b1);
        step("idle0", 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        check_out("idle0_out", 1'b0, 4'hA, 1'b1);

        // Contention: round-robin alternates starting with in0, fixed always in0
        step("cont0", 1'b1, 1'b1, 4'h3, 1'b1, 4'hC, 1'b1, 1'b1, 1'b0);
        step("cont1", 1'b1, 1'b1, 4'h3, 1'b1, 4'hC, 1'b1, !rr, rr);
        step("cont2", 1'b1, 1'b1, 4'h3, 1'b1, 4'hC, 1'b1, 1'b1, 1'b0);
        step("cont3", 1'b1, 1'b1, 4'h3, 1'b1, 4'hC, 1'b1, !rr, rr);

        // Load 5, then backpressure for 4 cycles
        step("load5", 1'b1, 1'b1, 4'h5, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_out("bp_hold", 1'b1, 4'h5, 1'b0);
            step("bp", 1'b1, 1'b1, 4'h3, 1'b1, 4'hC, 1'b0, 1'b0, 1'b0);
        end
        check_out("bp_release", 1'b1, 4'h5, 1'b0);
        step("release", 1'b1, 1'b1, 4'h3, 1'b1, 4'hC, 1'b1, !rr, rr);

        // Drain and refill in the same cycle
        check_out("refill_pre", 1'b1, rel_d, rel_s);
        step("refill", 1'b1, 1'b1, 4'h7, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        check_out("refill_out", 1'b1, 4'h7, 1'b0);
        step("hold7", 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

        // Reset with 9 buffered
        step("load9", 1'b1, 1'b1, 4'h9, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        check_out("pre_midrst", 1'b1, 4'h9, 1'b0);
        step("midrst", 1'b0, 1'b1, 4'h3, 1'b1, 4'hC, 1'b0, 1'b0, 1'b0);
        check_out("post_midrst", 1'b0, 4'h0, 1'b0);
        step("after_rst0", 1'b1, 1'b1, 4'h3, 1'b1, 4'hC, 1'b1, 1'b1, 1'b0);
        check_out("after_rst0_out", 1'b1, 4'h3, 1'b0);
        step("after_rst1", 1'b1, 1'b1, 4'h3, 1'b1, 4'hC, 1'b1, !rr, rr);
        step("drain0", 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        step("drain1", 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        check_out("final_out", 1'b0, rel_d, rel_s);

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d words pending, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mux_arb_2to1_4bit.md
# mux_arb_2to1_4bit

Two-requester arbiter and output stage for the shared 4-bit 2:1 select path. Each requester offers a WIDTH-bit word over valid/ready; the block picks one winner per cycle, drives the select internally, and registers the selected word into a single-entry output buffer with its own valid/ready handshake. It sits between two producers and the one downstream consumer of the shared 4-bit channel, and owns all sequencing of the select line.

## Interface
- WIDTH, 4, data width of each requester and of the output word

- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- in0_valid  input  1  requester 0 offers in0_data
- in0_data  input  WIDTH  requester 0 word
- in0_ready  output  1  requester 0 word accepted this cycle
- in1_valid  input  1  requester 1 offers in1_data
- in1_data  input  WIDTH  requester 1 word
- in1_ready  output  1  requester 1 word accepted this cycle
- out_valid  output  1  out_data/out_src hold a word
- out_data  output  WIDTH  registered selected word
- out_src  output  1  source of out_data (0 = in0, 1 = in1)
- out_ready  input  1  consumer takes the word this cycle

## Operation
- Clock is clk. Reset is synchronous and active-low on rst_n; the polarity and synchronicity are fixed.
- Output buffer has one entry with state EMPTY (out_valid=0) or FULL (out_valid=1).
- can_accept = !out_valid | out_ready, so the block can refill the buffer in the same cycle it drains.
- Arbitration is evaluated each cycle when can_accept=1:
  - Only in0_valid is high: grant 0.
  - Only in1_valid is high: grant 1.
  - Both are high: grant the input favoured by the priority pointer.
  - Neither is high: no grant.
- Exactly one of in0_ready/in1_ready is high, only for the granted input, and only when can_accept=1. Both are 0 otherwise.
- On a grant (inX_valid & inX_ready), the next edge loads out_data<=inX_data and out_src<=X, and sets out_valid<=1.
- On out_valid & out_ready with no new grant, the next edge sets out_valid<=0. out_data and out_src keep their last values.
- When the buffer is FULL and out_ready=0, out_data and out_src are held stable and both in*_ready are 0 (backpressure).
- Priority pointer: after each grant to X, the pointer favours !X. It updates only on an actual grant, not on idle or backpressured cycles.
- Requesters must hold valid and data until ready. Deasserting valid without ready is legal; the request is simply withdrawn.
- Reset values (rst_n low at an edge):
  - out_valid=0, out_data=0, out_src=0, pointer favours in0.
  - in0_ready and in1_ready are forced to 0 while rst_n=0.
  - Reset mid-transfer discards the buffered word with no output handshake.

## Timing
- in*_ready is combinational from the in*_valid inputs, out_valid, out_ready and the pointer. There is no combinational path from in*_data to any output.
- Latency: 1 cycle from the grant edge to out_valid/out_data.
- Throughput: one word per cycle when out_ready is held high. Arbitration alternates each cycle when both inputs are valid (round-robin build).
- The out_ready→in*_ready path is combinational (pass-through refill). There is no out_ready→out_valid combinational path.
- First edge with rst_n=1: the block may accept a word; out_valid rises one edge later.

## Configuration
- MUX_ARB_ROUND_ROBIN_EN
  - Defined: round-robin pointer as described above; starvation-free, with a worst-case wait of 1 grant.
  - Undefined: fixed priority. in0 wins every contention, the pointer register is not built, and in1 can starve while in0_valid stays high. All other behaviour is identical.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with both valids high. Required: in0_ready=in1_ready=0, out_valid=0, out_data=0, out_src=0.
- Single source: in1_valid=1, in1_data=4'hA, out_ready=1. Required: in1_ready=1 immediately, then out_valid=1, out_data=4'hA, out_src=1 on the next edge.
- Contention, round-robin: both valid continuously with in0_data=4'h3, in1_data=4'hC, out_ready=1. Required output sequence is out_src 0,1,0,1 and out_data 3,C,3,C. With the macro undefined, the required sequence is all 0 and all 4'h3.
- Backpressure: buffer FULL with 4'h5 and out_ready=0 for 4 cycles while both valids are high. Required: both ready=0 and out_data stays 4'h5. On release, 4'h5 drains and the next winner loads in the same cycle.
- Drain and refill in the same cycle: out_valid=1, out_ready=1, in0_valid=1, in0_data=4'h7. Required: in0_ready=1, out_valid stays 1, out_data=4'h7 after the edge.
- Reset mid-operation: pull rst_n low while out_valid=1 with data 4'h9. Required: after the edge out_valid=0 and out_data=0, and the next contention grants in0 first.
